// File: rtl/rop_frag_sched.sv
// rtl/rop_frag_sched.sv - per-fragment ROP sequencer driving the shared memory port and ds/blend handshakes
module rop_frag_sched (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_frag_valid,
  output logic        o_frag_ready,
  input  logic [15:0] i_frag_pos_x,
  input  logic [15:0] i_frag_pos_y,
  input  logic [31:0] i_frag_color,
  input  logic [31:0] i_zbuf_addr,
  input  logic [31:0] i_zbuf_pitch,
  input  logic [31:0] i_cbuf_addr,
  input  logic [31:0] i_cbuf_pitch,
  input  logic [31:0] i_cbuf_mask,
  input  logic        i_ds_enable,
  input  logic        i_blend_enable,
  output logic        o_mem_req_valid,
  input  logic        i_mem_req_ready,
  output logic        o_mem_req_rw,
  output logic [31:0] o_mem_req_addr,
  output logic [31:0] o_mem_req_data,
  output logic [3:0]  o_mem_req_byteen,
  input  logic        i_mem_rsp_valid,
  output logic        o_mem_rsp_ready,
  input  logic [31:0] i_mem_rsp_data,
  output logic        o_ds_req_valid,
  input  logic        i_ds_req_ready,
  output logic [31:0] o_ds_req_zs,
  input  logic        i_ds_rsp_valid,
  input  logic        i_ds_rsp_pass,
  input  logic        i_ds_rsp_write,
  input  logic [31:0] i_ds_rsp_zs,
  output logic        o_blend_req_valid,
  input  logic        i_blend_req_ready,
  output logic [31:0] o_blend_req_dst,
  input  logic        i_blend_rsp_valid,
  input  logic [31:0] i_blend_rsp_color,
  output logic [31:0] o_frag_count,
  output logic [31:0] o_kill_count
);

  typedef enum logic [3:0] {
    S_IDLE, S_ZRD, S_ZWAIT, S_DSTEST, S_ZWR, S_CRD, S_CWAIT, S_BLEND, S_CWR
  } state_t;

  state_t      r_state;
  logic [31:0] r_zaddr;
  logic [31:0] r_caddr;
  logic [31:0] r_color;
  logic [31:0] r_mask;
  logic        r_blend_en;
  logic        r_pass;
  logic        r_wait;   // DSTEST/BLEND: request accepted, waiting for the result strobe

  logic [31:0] w_zaddr;
  logic [31:0] w_caddr;
  logic        w_in_idle;
  logic        w_blend_sel;
  logic [31:0] w_mask_sel;
  logic [31:0] w_caddr_sel;
  logic [31:0] w_color_sel;
  logic [3:0]  w_mask_be;
  state_t      w_cs_state;
  logic        w_cs_valid;
  logic [3:0]  w_cs_byteen;

  assign w_zaddr = i_zbuf_addr + 32'(i_frag_pos_y) * i_zbuf_pitch + {14'd0, i_frag_pos_x, 2'b00};
  assign w_caddr = i_cbuf_addr + 32'(i_frag_pos_y) * i_cbuf_pitch + {14'd0, i_frag_pos_x, 2'b00};

  // Entry into the colour stage happens from IDLE (live inputs) or after the ds stage (latched copies)
  assign w_in_idle   = (r_state == S_IDLE);
  assign w_blend_sel = w_in_idle ? i_blend_enable : r_blend_en;
  assign w_mask_sel  = w_in_idle ? i_cbuf_mask    : r_mask;
  assign w_caddr_sel = w_in_idle ? w_caddr        : r_caddr;
  assign w_color_sel = w_in_idle ? i_frag_color   : r_color;
  assign w_mask_be   = {|w_mask_sel[31:24], |w_mask_sel[23:16], |w_mask_sel[15:8], |w_mask_sel[7:0]};
  assign w_cs_state  = w_blend_sel ? S_CRD : S_CWR;
  assign w_cs_valid  = w_blend_sel | (|w_mask_sel);
  assign w_cs_byteen = w_blend_sel ? 4'hF : w_mask_be;

  // Sequencer FSM with all handshake outputs registered
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state           <= S_IDLE;
      r_zaddr           <= 32'd0;
      r_caddr           <= 32'd0;
      r_color           <= 32'd0;
      r_mask            <= 32'd0;
      r_blend_en        <= 1'b0;
      r_pass            <= 1'b0;
      r_wait            <= 1'b0;
      o_frag_ready      <= 1'b1;
      o_mem_req_valid   <= 1'b0;
      o_mem_req_rw      <= 1'b0;
      o_mem_req_addr    <= 32'd0;
      o_mem_req_data    <= 32'd0;
      o_mem_req_byteen  <= 4'd0;
      o_mem_rsp_ready   <= 1'b0;
      o_ds_req_valid    <= 1'b0;
      o_ds_req_zs       <= 32'd0;
      o_blend_req_valid <= 1'b0;
      o_blend_req_dst   <= 32'd0;
      o_frag_count      <= 32'd0;
      o_kill_count      <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: if (i_frag_valid) begin
          o_frag_ready <= 1'b0;
          r_zaddr      <= w_zaddr;
          r_caddr      <= w_caddr;
          r_color      <= i_frag_color;
          r_mask       <= i_cbuf_mask;
          r_blend_en   <= i_blend_enable;
          if (i_ds_enable) begin
            r_state          <= S_ZRD;
            o_mem_req_valid  <= 1'b1;
            o_mem_req_rw     <= 1'b0;
            o_mem_req_addr   <= w_zaddr;
            o_mem_req_byteen <= 4'hF;
          end else begin
            r_state          <= w_cs_state;
            o_mem_req_valid  <= w_cs_valid;
            o_mem_req_rw     <= ~w_blend_sel;
            o_mem_req_addr   <= w_caddr_sel;
            o_mem_req_data   <= w_color_sel;
            o_mem_req_byteen <= w_cs_byteen;
          end
        end
        S_ZRD, S_CRD: if (i_mem_req_ready) begin
          o_mem_req_valid <= 1'b0;
          o_mem_rsp_ready <= 1'b1;
          r_state         <= (r_state == S_ZRD) ? S_ZWAIT : S_CWAIT;
        end
        S_ZWAIT: if (i_mem_rsp_valid) begin
          o_mem_rsp_ready <= 1'b0;
          o_ds_req_zs     <= i_mem_rsp_data;
          o_ds_req_valid  <= 1'b1;
          r_wait          <= 1'b0;
          r_state         <= S_DSTEST;
        end
        S_DSTEST: if (!r_wait) begin
          if (i_ds_req_ready) begin
            o_ds_req_valid <= 1'b0;
            r_wait         <= 1'b1;
          end
        end else if (i_ds_rsp_valid) begin
          r_wait <= 1'b0;
          r_pass <= i_ds_rsp_pass;
          if (i_ds_rsp_write) begin
            r_state          <= S_ZWR;
            o_mem_req_valid  <= 1'b1;
            o_mem_req_rw     <= 1'b1;
            o_mem_req_addr   <= r_zaddr;
            o_mem_req_data   <= i_ds_rsp_zs;
            o_mem_req_byteen <= 4'hF;
          end else if (i_ds_rsp_pass) begin
            r_state          <= w_cs_state;
            o_mem_req_valid  <= w_cs_valid;
            o_mem_req_rw     <= ~w_blend_sel;
            o_mem_req_addr   <= w_caddr_sel;
            o_mem_req_data   <= w_color_sel;
            o_mem_req_byteen <= w_cs_byteen;
          end else begin
            o_kill_count <= o_kill_count + 32'd1;
            o_frag_ready <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        S_ZWR: if (i_mem_req_ready) begin
          if (r_pass) begin
            r_state          <= w_cs_state;
            o_mem_req_valid  <= w_cs_valid;
            o_mem_req_rw     <= ~w_blend_sel;
            o_mem_req_addr   <= w_caddr_sel;
            o_mem_req_data   <= w_color_sel;
            o_mem_req_byteen <= w_cs_byteen;
          end else begin
            o_mem_req_valid <= 1'b0;
            o_kill_count    <= o_kill_count + 32'd1;
            o_frag_ready    <= 1'b1;
            r_state         <= S_IDLE;
          end
        end
        S_CWAIT: if (i_mem_rsp_valid) begin
          o_mem_rsp_ready   <= 1'b0;
          o_blend_req_dst   <= i_mem_rsp_data;
          o_blend_req_valid <= 1'b1;
          r_wait            <= 1'b0;
          r_state           <= S_BLEND;
        end
        S_BLEND: if (!r_wait) begin
          if (i_blend_req_ready) begin
            o_blend_req_valid <= 1'b0;
            r_wait            <= 1'b1;
          end
        end else if (i_blend_rsp_valid) begin
          r_wait           <= 1'b0;
          r_state          <= S_CWR;
          o_mem_req_valid  <= |r_mask;
          o_mem_req_rw     <= 1'b1;
          o_mem_req_addr   <= r_caddr;
          o_mem_req_data   <= i_blend_rsp_color;
          o_mem_req_byteen <= w_mask_be;
        end
        S_CWR: if (!o_mem_req_valid || i_mem_req_ready) begin
          o_mem_req_valid <= 1'b0;
          o_frag_count    <= o_frag_count + 32'd1;
          o_frag_ready    <= 1'b1;
          r_state         <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rop_frag_sched.sv
// tb/tb_rop_frag_sched.sv - directed self-checking bench for rop_frag_sched
module tb_rop_frag_sched;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_frag_valid;
  logic        o_frag_ready;
  logic [15:0] i_frag_pos_x, i_frag_pos_y;
  logic [31:0] i_frag_color, i_zbuf_addr, i_zbuf_pitch, i_cbuf_addr, i_cbuf_pitch, i_cbuf_mask;
  logic        i_ds_enable, i_blend_enable;
  logic        o_mem_req_valid, i_mem_req_ready, o_mem_req_rw;
  logic [31:0] o_mem_req_addr, o_mem_req_data;
  logic [3:0]  o_mem_req_byteen;
  logic        i_mem_rsp_valid, o_mem_rsp_ready;
  logic [31:0] i_mem_rsp_data;
  logic        o_ds_req_valid, i_ds_req_ready;
  logic [31:0] o_ds_req_zs;
  logic        i_ds_rsp_valid, i_ds_rsp_pass, i_ds_rsp_write;
  logic [31:0] i_ds_rsp_zs;
  logic        o_blend_req_valid, i_blend_req_ready;
  logic [31:0] o_blend_req_dst;
  logic        i_blend_rsp_valid;
  logic [31:0] i_blend_rsp_color;
  logic [31:0] o_frag_count, o_kill_count;

  int n_vec = 0;
  int n_err = 0;
  int lat;
  int n_wr;
  logic done, ds_pend, bl_pend, ds_nxt, bl_nxt;

  always #5 i_clk = ~i_clk;

  rop_frag_sched dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_frag_valid(i_frag_valid), .o_frag_ready(o_frag_ready),
    .i_frag_pos_x(i_frag_pos_x), .i_frag_pos_y(i_frag_pos_y), .i_frag_color(i_frag_color),
    .i_zbuf_addr(i_zbuf_addr), .i_zbuf_pitch(i_zbuf_pitch),
    .i_cbuf_addr(i_cbuf_addr), .i_cbuf_pitch(i_cbuf_pitch), .i_cbuf_mask(i_cbuf_mask),
    .i_ds_enable(i_ds_enable), .i_blend_enable(i_blend_enable),
    .o_mem_req_valid(o_mem_req_valid), .i_mem_req_ready(i_mem_req_ready),
    .o_mem_req_rw(o_mem_req_rw), .o_mem_req_addr(o_mem_req_addr),
    .o_mem_req_data(o_mem_req_data), .o_mem_req_byteen(o_mem_req_byteen),
    .i_mem_rsp_valid(i_mem_rsp_valid), .o_mem_rsp_ready(o_mem_rsp_ready),
    .i_mem_rsp_data(i_mem_rsp_data),
    .o_ds_req_valid(o_ds_req_valid), .i_ds_req_ready(i_ds_req_ready), .o_ds_req_zs(o_ds_req_zs),
    .i_ds_rsp_valid(i_ds_rsp_valid), .i_ds_rsp_pass(i_ds_rsp_pass),
    .i_ds_rsp_write(i_ds_rsp_write), .i_ds_rsp_zs(i_ds_rsp_zs),
    .o_blend_req_valid(o_blend_req_valid), .i_blend_req_ready(i_blend_req_ready),
    .o_blend_req_dst(o_blend_req_dst),
    .i_blend_rsp_valid(i_blend_rsp_valid), .i_blend_rsp_color(i_blend_rsp_color),
    .o_frag_count(o_frag_count), .o_kill_count(o_kill_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    i_reset = 1'b1; i_frag_valid = 1'b0; i_frag_pos_x = 16'd2; i_frag_pos_y = 16'd3;
    i_frag_color = 32'hAABBCCDD; i_zbuf_addr = 32'h2000; i_zbuf_pitch = 32'h40;
    i_cbuf_addr = 32'h1000; i_cbuf_pitch = 32'h100; i_cbuf_mask = 32'hFFFFFFFF;
    i_ds_enable = 1'b0; i_blend_enable = 1'b0; i_mem_req_ready = 1'b0;
    i_mem_rsp_valid = 1'b0; i_mem_rsp_data = 32'd0; i_ds_req_ready = 1'b0;
    i_ds_rsp_valid = 1'b0; i_ds_rsp_pass = 1'b0; i_ds_rsp_write = 1'b0; i_ds_rsp_zs = 32'd0;
    i_blend_req_ready = 1'b0; i_blend_rsp_valid = 1'b0; i_blend_rsp_color = 32'd0;
    tick; tick;
    i_reset = 1'b0;
    tick;
    chk("rst_frag_ready", o_frag_ready, 1);
    chk("rst_mem_req_valid", o_mem_req_valid, 0);
    chk("rst_mem_req_addr", o_mem_req_addr, 0);
    chk("rst_frag_count", o_frag_count, 0);
    chk("rst_kill_count", o_kill_count, 0);

    // Colour-only fragment: single write at 0x1308
    i_frag_valid = 1'b1;
    tick;
    i_frag_valid = 1'b0;
    chk("t1_frag_ready", o_frag_ready, 0);
    chk("t1_valid", o_mem_req_valid, 1);
    chk("t1_rw", o_mem_req_rw, 1);
    chk("t1_addr", o_mem_req_addr, 32'h1308);
    chk("t1_data", o_mem_req_data, 32'hAABBCCDD);
    chk("t1_byteen", o_mem_req_byteen, 4'hF);
    chk("t1_count_pre", o_frag_count, 0);
    i_mem_req_ready = 1'b1;
    tick;
    i_mem_req_ready = 1'b0;
    chk("t1_count", o_frag_count, 1);
    chk("t1_valid_off", o_mem_req_valid, 0);
    chk("t1_frag_ready_back", o_frag_ready, 1);

    // Zero colour mask: no write, retire straight away
    i_cbuf_mask = 32'h0;
    i_frag_valid = 1'b1;
    tick;
    i_frag_valid = 1'b0;
    chk("m0_no_valid", o_mem_req_valid, 0);
    tick;
    chk("m0_count", o_frag_count, 2);

    // Depth test fails: z read only, then kill
    i_ds_enable = 1'b1; i_blend_enable = 1'b1; i_cbuf_mask = 32'hFFFFFFFF;
    i_frag_pos_x = 16'd1; i_frag_pos_y = 16'd1;
    i_frag_valid = 1'b1;
    tick;
    i_frag_valid = 1'b0;
    chk("t2_zrd_addr", o_mem_req_addr, 32'h2044);
    chk("t2_zrd_rw", o_mem_req_rw, 0);
    i_mem_req_ready = 1'b1;
    tick;
    i_mem_req_ready = 1'b0;
    chk("t2_rsp_ready", o_mem_rsp_ready, 1);
    chk("t2_valid_off", o_mem_req_valid, 0);
    i_mem_rsp_valid = 1'b1; i_mem_rsp_data = 32'h00123456;
    tick;
    i_mem_rsp_valid = 1'b0;
    chk("t2_ds_valid", o_ds_req_valid, 1);
    chk("t2_ds_zs", o_ds_req_zs, 32'h00123456);
    chk("t2_rsp_ready_off", o_mem_rsp_ready, 0);
    i_ds_req_ready = 1'b1;
    tick;
    i_ds_req_ready = 1'b0;
    chk("t2_ds_valid_off", o_ds_req_valid, 0);
    i_ds_rsp_valid = 1'b1; i_ds_rsp_pass = 1'b0; i_ds_rsp_write = 1'b0;
    tick;
    i_ds_rsp_valid = 1'b0;
    chk("t2_kill", o_kill_count, 1);
    chk("t2_frag_count", o_frag_count, 2);
    tick; tick;
    chk("t2_no_cbuf", o_mem_req_valid, 0);

    // Full path with z write-back, blend, masked colour write stalled 5 cycles
    i_frag_pos_x = 16'd2; i_frag_pos_y = 16'd3; i_cbuf_mask = 32'h00FF00FF;
    i_frag_valid = 1'b1;
    tick;
    i_frag_valid = 1'b0;
    chk("t3_zrd_addr", o_mem_req_addr, 32'h20C8);
    i_mem_req_ready = 1'b1;
    tick;
    i_mem_req_ready = 1'b0;
    i_mem_rsp_valid = 1'b1; i_mem_rsp_data = 32'hCAFE0001;
    tick;
    i_mem_rsp_valid = 1'b0;
    chk("t3_ds_zs", o_ds_req_zs, 32'hCAFE0001);
    i_ds_req_ready = 1'b1;
    tick;
    i_ds_req_ready = 1'b0;
    i_ds_rsp_valid = 1'b1; i_ds_rsp_pass = 1'b1; i_ds_rsp_write = 1'b1; i_ds_rsp_zs = 32'h7;
    tick;
    i_ds_rsp_valid = 1'b0;
    chk("t3_zwr_rw", o_mem_req_rw, 1);
    chk("t3_zwr_addr", o_mem_req_addr, 32'h20C8);
    chk("t3_zwr_data", o_mem_req_data, 32'h7);
    chk("t3_zwr_byteen", o_mem_req_byteen, 4'hF);
    i_mem_req_ready = 1'b1;
    tick;
    i_mem_req_ready = 1'b0;
    chk("t3_crd_valid", o_mem_req_valid, 1);
    chk("t3_crd_rw", o_mem_req_rw, 0);
    chk("t3_crd_addr", o_mem_req_addr, 32'h1308);
    i_mem_req_ready = 1'b1;
    tick;
    i_mem_req_ready = 1'b0;
    i_mem_rsp_valid = 1'b1; i_mem_rsp_data = 32'h55667788;
    tick;
    i_mem_rsp_valid = 1'b0;
    chk("t3_blend_valid", o_blend_req_valid, 1);
    chk("t3_blend_dst", o_blend_req_dst, 32'h55667788);
    i_blend_req_ready = 1'b1;
    tick;
    i_blend_req_ready = 1'b0;
    chk("t3_blend_valid_off", o_blend_req_valid, 0);
    i_blend_rsp_valid = 1'b1; i_blend_rsp_color = 32'h11223344;
    tick;
    i_blend_rsp_valid = 1'b0;
    n_wr = 0;
    for (int c = 0; c < 5; c++) begin
      chk("t4_stall_valid", o_mem_req_valid, 1);
      chk("t4_stall_addr", o_mem_req_addr, 32'h1308);
      chk("t4_stall_data", o_mem_req_data, 32'h11223344);
      chk("t4_stall_byteen", o_mem_req_byteen, 4'h5);
      chk("t4_stall_count", o_frag_count, 2);
      tick;
    end
    chk("t4_rw", o_mem_req_rw, 1);
    i_mem_req_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (o_mem_req_valid && i_mem_req_ready) n_wr++;
      tick;
    end
    i_mem_req_ready = 1'b0;
    chk("t4_single_write", n_wr, 1);
    chk("t4_count", o_frag_count, 3);
    chk("t4_kill_same", o_kill_count, 1);

    // Zero-wait latency, all stages, no z write-back
    i_cbuf_mask = 32'hFFFFFFFF; i_ds_rsp_write = 1'b0; i_ds_rsp_pass = 1'b1;
    i_mem_req_ready = 1'b1; i_ds_req_ready = 1'b1; i_blend_req_ready = 1'b1;
    i_mem_rsp_data = 32'h1; i_blend_rsp_color = 32'h2;
    ds_pend = 1'b0; bl_pend = 1'b0; done = 1'b0; lat = 0;
    i_frag_valid = 1'b1;
    tick;
    i_frag_valid = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      i_mem_rsp_valid = o_mem_rsp_ready;
      i_ds_rsp_valid = ds_pend;
      i_blend_rsp_valid = bl_pend;
      ds_nxt = o_ds_req_valid;
      bl_nxt = o_blend_req_valid;
      tick;
      lat++;
      ds_pend = ds_nxt;
      bl_pend = bl_nxt;
      if (o_frag_count == 32'd4) done = 1'b1;
    end
    i_mem_rsp_valid = 1'b0; i_ds_rsp_valid = 1'b0; i_blend_rsp_valid = 1'b0;
    i_mem_req_ready = 1'b0; i_ds_req_ready = 1'b0; i_blend_req_ready = 1'b0;
    chk("lat_done", done, 1);
    chk("lat_cycles", lat, 9);

    // Reset in CWAIT drops the fragment
    i_ds_enable = 1'b0; i_blend_enable = 1'b1;
    i_frag_valid = 1'b1;
    tick;
    i_frag_valid = 1'b0;
    chk("r_crd_addr", o_mem_req_addr, 32'h1308);
    i_mem_req_ready = 1'b1;
    tick;
    i_mem_req_ready = 1'b0;
    chk("r_cwait_rsp_ready", o_mem_rsp_ready, 1);
    i_reset = 1'b1;
    #1;
    chk("r_rsp_ready", o_mem_rsp_ready, 0);
    chk("r_frag_ready", o_frag_ready, 1);
    chk("r_frag_count", o_frag_count, 0);
    chk("r_kill_count", o_kill_count, 0);
    chk("r_addr", o_mem_req_addr, 0);
    tick;
    i_reset = 1'b0;
    i_blend_enable = 1'b0;
    i_frag_valid = 1'b1;
    tick;
    i_frag_valid = 1'b0;
    chk("r2_addr", o_mem_req_addr, 32'h1308);
    chk("r2_data", o_mem_req_data, 32'hAABBCCDD);
    i_mem_req_ready = 1'b1;
    tick;
    i_mem_req_ready = 1'b0;
    chk("r2_count", o_frag_count, 1);

    // Z address wraps modulo 2^32
    i_ds_enable = 1'b1; i_zbuf_addr = 32'hFFFFFFF0; i_zbuf_pitch = 32'h100;
    i_frag_pos_x = 16'd8; i_frag_pos_y = 16'd0;
    i_frag_valid = 1'b1;
    tick;
    i_frag_valid = 1'b0;
    chk("wrap_zaddr", o_mem_req_addr, 32'h00000010);
    i_mem_req_ready = 1'b1;
    tick;
    i_mem_req_ready = 1'b0;
    i_mem_rsp_valid = 1'b1;
    tick;
    i_mem_rsp_valid = 1'b0;
    i_ds_req_ready = 1'b1;
    tick;
    i_ds_req_ready = 1'b0;
    i_ds_rsp_valid = 1'b1; i_ds_rsp_pass = 1'b0;
    tick;
    i_ds_rsp_valid = 1'b0;
    chk("wrap_kill", o_kill_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
